lane_shifter: RTL and testbench

LANE_SHIFTER -- requirements
Module: lane_shifter

---
 rtl/lane_shifter_pkg.sv | 23 ++
 rtl/lane_shift_core.sv | 67 ++++++
 rtl/lane_shifter.sv | 100 ++++++++++
 tb/tb_lane_shifter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_shifter_pkg.sv
// Shared types and defaults for the lane shifter.
package lane_shifter_pkg;

    typedef enum logic [1:0] {
        SHL_FILL = 2'd0,
        SHR_FILL = 2'd1,
        ROL      = 2'd2,
        RSVD     = 2'd3
    } mode_e;

    localparam int unsigned LANE_W_DEF    = 12;
    localparam int unsigned LANES_DEF     = 8;
    localparam int unsigned MAX_SHIFT_DEF = 5;

    function automatic logic beat_illegal(
        input int unsigned shift,
        input int unsigned max_shift,
        input mode_e       mode
    );
        return (shift > max_shift) || (mode == RSVD);
    endfunction

endpackage

// File: rtl/lane_shift_core.sv
// Combinational lane mux network: shift/rotate whole lanes, fill vacated lanes,
// and force an all-fill word when the beat is illegal.
module lane_shift_core
    import lane_shifter_pkg::*;
#(
    parameter int unsigned LANE_W    = LANE_W_DEF,
    parameter int unsigned LANES     = LANES_DEF,
    parameter int unsigned MAX_SHIFT = MAX_SHIFT_DEF,
    parameter int unsigned SH_W      = $clog2(LANES)
) (
    input  logic [LANES*LANE_W-1:0] data_in,
    input  logic [SH_W-1:0]         shift,
    input  mode_e                   mode,
    input  logic [LANE_W-1:0]       fill,
    output logic [LANES*LANE_W-1:0] data_out,
    output logic                    err
);

    localparam int          NL    = int'(LANES);
    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANE_W-1:0] lane_in [LANES];
    int                k;

    assign k   = int'(shift);
    assign err = beat_illegal(32'(shift), MAX_SHIFT, mode);

    for (genvar g = 0; g < NL; g++) begin : g_lane
        int                src;
        logic              keep;
        logic [IDX_W-1:0]  idx;
        logic [LANE_W-1:0] lane_val;

        assign lane_in[g] = data_in[g*LANE_W +: LANE_W];

        // src is the input lane feeding output lane g; keep is low for vacated lanes.
        always_comb begin
            src  = 0;
            keep = 1'b0;
            unique case (mode)
                SHL_FILL: begin
                    src  = g - k;
                    keep = (src >= 0);
                end
                SHR_FILL: begin
                    src  = g + k;
                    keep = (src < NL);
                end
                ROL: begin
                    src = g - k;
                    if (src < 0) begin
                        src = src + NL;
                    end
                    keep = 1'b1;
                end
                default: begin
                    keep = 1'b0;
                end
            endcase
            idx      = IDX_W'(src);
            lane_val = (keep && !err) ? lane_in[idx] : fill;
        end

        assign data_out[g*LANE_W +: LANE_W] = lane_val;
    end

endmodule

// File: rtl/lane_shifter.sv
// Two-stage elastic lane shifter: stage 1 registers the request, stage 2 the
// shifted result, with a saturating count of errored output beats.
module lane_shifter
    import lane_shifter_pkg::*;
#(
    parameter int unsigned LANE_W    = LANE_W_DEF,
    parameter int unsigned LANES     = LANES_DEF,
    parameter int unsigned MAX_SHIFT = MAX_SHIFT_DEF,
    parameter int unsigned SH_W      = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_data,
    input  logic [SH_W-1:0]         in_shift,
    input  logic [1:0]              in_mode,
    input  logic [LANE_W-1:0]       in_fill,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic                    out_err,
    output logic [15:0]             err_cnt
);

    localparam int unsigned DW = LANES * LANE_W;

    logic              s1_valid;
    logic [DW-1:0]     s1_data;
    logic [SH_W-1:0]   s1_shift;
    mode_e             s1_mode;
    logic [LANE_W-1:0] s1_fill;
    logic              s1_ready;

    logic              s2_valid;
    logic [DW-1:0]     s2_data;
    logic              s2_err;
    logic              s2_ready;

    logic [DW-1:0]     core_data;
    logic              core_err;

    assign s2_ready  = !s2_valid || out_ready;
    assign s1_ready  = !s1_valid || s2_ready;
    // Reset discards everything in flight, so the input may be offered as ready.
    assign in_ready  = s1_ready || rst;

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_err   = s2_err;

    lane_shift_core #(
        .LANE_W    (LANE_W),
        .LANES     (LANES),
        .MAX_SHIFT (MAX_SHIFT),
        .SH_W      (SH_W)
    ) u_core (
        .data_in  (s1_data),
        .shift    (s1_shift),
        .mode     (s1_mode),
        .fill     (s1_fill),
        .data_out (core_data),
        .err      (core_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_shift <= '0;
            s1_mode  <= SHL_FILL;
            s1_fill  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_err   <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (s1_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data  <= in_data;
                    s1_shift <= in_shift;
                    s1_mode  <= mode_e'(in_mode);
                    s1_fill  <= in_fill;
                end
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= core_data;
                    s2_err  <= core_err;
                end
            end
            if (s2_valid && out_ready && s2_err && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_lane_shifter.sv
// Bench for lane_shifter: directed vector table, randomized traffic against a
// queue-based lane model, backpressure, mid-flight reset and counter saturation.
module tb_lane_shifter;

    localparam int unsigned LANE_W    = 12;
    localparam int unsigned LANES     = 8;
    localparam int unsigned MAX_SHIFT = 5;
    localparam int unsigned SH_W      = 3;
    localparam int unsigned DW        = LANE_W * LANES;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [SH_W-1:0]   in_shift;
    logic [1:0]        in_mode;
    logic [LANE_W-1:0] in_fill;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic              out_err;
    logic [15:0]       err_cnt;

    lane_shifter #(
        .LANE_W    (LANE_W),
        .LANES     (LANES),
        .MAX_SHIFT (MAX_SHIFT),
        .SH_W      (SH_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_mode   (in_mode),
        .in_fill   (in_fill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_cnt(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [DW-1:0] got,
                             input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // Reference model: lane 0 at the queue front; shifts move whole lanes.
    function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] data, input int k,
                                                input int mode, input logic [LANE_W-1:0] fill,
                                                output logic err);
        logic [LANE_W-1:0] lanes[$];
        logic [LANE_W-1:0] t;
        logic [DW-1:0]     r;
        err = (k > int'(MAX_SHIFT)) || (mode == 3);
        for (int j = 0; j < int'(LANES); j++) begin
            lanes.push_back(err ? fill : data[j*LANE_W +: LANE_W]);
        end
        if (!err) begin
            repeat (k) begin
                case (mode)
                    0: begin
                        lanes.push_front(fill);
                        t = lanes.pop_back();
                    end
                    1: begin
                        t = lanes.pop_front();
                        lanes.push_back(fill);
                    end
                    default: begin
                        t = lanes.pop_back();
                        lanes.push_front(t);
                    end
                endcase
            end
        end
        for (int j = 0; j < int'(LANES); j++) begin
            r[j*LANE_W +: LANE_W] = lanes[j];
        end
        return r;
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_cnt;
    logic        prev_stall;
    logic        m_e;
    logic [DW-1:0] m_d;
    exp_t        m_front;

    // Scoreboard: decisions at the negedge describe the transfers of the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_cnt      = 16'd0;
            prev_stall = 1'b0;
            check_bit("reset_in_ready", in_ready, 1'b1);
        end else begin
            check_bit("in_ready", in_ready, !((exp_q.size() == 2) && !out_ready));
            check_cnt("err_cnt", err_cnt, m_cnt);
            if (prev_stall) begin
                check_bit("stall_valid", out_valid, 1'b1);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    fail_timeout("unexpected_output_beat");
                end else begin
                    m_front = exp_q[0];
                    check_vec("out_data", out_data, m_front.data);
                    check_bit("out_err", out_err, m_front.err);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                        if (m_front.err && (m_cnt != 16'hFFFF)) begin
                            m_cnt = m_cnt + 16'd1;
                        end
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            if (in_valid && in_ready) begin
                m_d = ref_shift(in_data, int'(in_shift), int'(in_mode), in_fill, m_e);
                exp_q.push_back('{data: m_d, err: m_e});
            end
        end
    end

    function automatic logic [DW-1:0] rand_word();
        return DW'({$urandom, $urandom, $urandom});
    endfunction

    // All driving tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [DW-1:0] d, input int k, input int m,
                        input logic [LANE_W-1:0] f);
        bit done;
        done     = 1'b0;
        in_data  = d;
        in_shift = SH_W'(k);
        in_mode  = 2'(m);
        in_fill  = f;
        in_valid = 1'b1;
        for (int g = 0; g < 100 && !done; g++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) fail_timeout("send_accept");
    endtask

    task automatic burst(input int n, input int m, input int k);
        int sent;
        int guard;
        sent     = 0;
        guard    = 0;
        in_mode  = 2'(m);
        in_shift = SH_W'(k);
        in_valid = 1'b1;
        while (sent < n && guard < n + 200) begin
            in_data = rand_word();
            in_fill = LANE_W'($urandom);
            @(negedge clk);
            if (in_ready) sent++;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (sent < n) fail_timeout("burst_accept");
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        int            shift;
        int            mode;
        logic [DW-1:0] exp_data;
        logic          exp_err;
    } vec_t;

    vec_t          tbl[10];
    logic [DW-1:0] base;
    logic [DW-1:0] all_fill;
    logic [15:0]   tcnt;
    bit            pat[4];
    int            sent;
    int            cyc;
    int            base_out;
    bit            acc;

    task automatic load_bp(input int b);
        for (int j = 0; j < int'(LANES); j++) begin
            in_data[j*LANE_W +: LANE_W] = LANE_W'(b * 16 + j);
        end
        in_shift = SH_W'(b % 6);
        in_mode  = 2'(b % 3);
        in_fill  = LANE_W'($urandom);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        in_mode   = '0;
        in_fill   = '0;
        out_ready = 1'b1;

        for (int j = 0; j < int'(LANES); j++) base[j*LANE_W +: LANE_W] = LANE_W'(j + 1);
        all_fill = {LANES{12'hABC}};
        tbl[0] = '{2, 0, {12'h006, 12'h005, 12'h004, 12'h003, 12'h002, 12'h001,
                          12'hABC, 12'hABC}, 1'b0};
        tbl[1] = '{3, 2, {12'h005, 12'h004, 12'h003, 12'h002, 12'h001, 12'h008,
                          12'h007, 12'h006}, 1'b0};
        tbl[2] = '{5, 1, {12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'h008,
                          12'h007, 12'h006}, 1'b0};
        tbl[3] = '{6, 0, all_fill, 1'b1};
        tbl[4] = '{1, 3, all_fill, 1'b1};
        tbl[5] = '{0, 2, base, 1'b0};
        tbl[6] = '{0, 1, base, 1'b0};
        tbl[7] = '{5, 0, {12'h003, 12'h002, 12'h001, 12'hABC, 12'hABC, 12'hABC,
                          12'hABC, 12'hABC}, 1'b0};
        tbl[8] = '{7, 2, all_fill, 1'b1};
        tbl[9] = '{0, 3, all_fill, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_out_err", out_err, 1'b0);
        check_vec("rst_out_data", out_data, '0);
        check_cnt("rst_err_cnt", err_cnt, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_bit("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Directed table: latency, result and counter per vector
        tcnt = 16'd0;
        for (int i = 0; i < 10; i++) begin
            send(base, tbl[i].shift, tbl[i].mode, 12'hABC);
            @(negedge clk);
            check_bit($sformatf("tbl%0d_lat1", i), out_valid, 1'b0);
            @(negedge clk);
            check_bit($sformatf("tbl%0d_lat2", i), out_valid, 1'b1);
            check_vec($sformatf("tbl%0d_data", i), out_data, tbl[i].exp_data);
            check_bit($sformatf("tbl%0d_err", i), out_err, tbl[i].exp_err);
            tcnt = tcnt + 16'(tbl[i].exp_err);
            @(negedge clk);
            check_cnt($sformatf("tbl%0d_cnt", i), err_cnt, tcnt);
            @(posedge clk);
            #1;
        end

        // Randomized traffic with random backpressure
        repeat (600) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = rand_word();
            in_shift  = SH_W'($urandom_range(0, 7));
            in_mode   = 2'($urandom_range(0, 3));
            in_fill   = LANE_W'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(6);
        @(negedge clk);
        check_cnt("random_drain", 16'(exp_q.size()), 16'd0);
        @(posedge clk);
        #1;

        // Ten back-to-back beats against an out_ready pattern 1,0,0,1
        pat      = '{1'b1, 1'b0, 1'b0, 1'b1};
        base_out = n_out;
        sent     = 0;
        cyc      = 0;
        load_bp(0);
        while ((n_out - base_out) < 10 && cyc < 300) begin
            out_ready = pat[cyc % 4];
            in_valid  = (sent < 10);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                load_bp(sent);
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_cnt("bp_beats_out", 16'(n_out - base_out), 16'd10);
        idle(2);

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(rand_word(), 6, 0, 12'h123);
        send(rand_word(), 1, 2, 12'h456);
        rst = 1'b1;
        @(negedge clk);
        check_bit("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_bit("midrst_out_valid", out_valid, 1'b0);
        check_cnt("midrst_err_cnt", err_cnt, 16'd0);
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_bit("midrst_no_stale", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        // Counter saturation
        out_ready = 1'b1;
        burst(65534, 3, 0);
        idle(4);
        @(negedge clk);
        check_cnt("sat_fffe", err_cnt, 16'hFFFE);
        @(posedge clk);
        #1;
        burst(3, 0, 7);
        idle(4);
        @(negedge clk);
        check_cnt("sat_ffff", err_cnt, 16'hFFFF);
        @(posedge clk);
        #1;
        burst(2, 3, 1);
        idle(4);
        @(negedge clk);
        check_cnt("sat_hold", err_cnt, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
